sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM command port between the ROM/PRG downloader write stream and the CPU.
- Downloader writes are single-cycle strobes with no back-pressure, so they are absorbed in a small FIFO.
- The CPU uses a req/ack handshake.
- While a download is active, or writes are still pending, the CPU is held off via cpu_wait, so the downloader never loses data.

Parameters:
- ADDR_W, 25, address width (all address ports).
- DATA_W, 8, data width (all data ports).
- FIFO_DEPTH, 4, downloader write FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dl_downloading  in  1  downloader active flag
- dl_wr  in  1  one-cycle write strobe from downloader
- dl_addr  in  ADDR_W  downloader write address
- dl_data  in  DATA_W  downloader write data
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_din  in  DATA_W  CPU write data
- cpu_dout  out  DATA_W  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_wait  out  1  CPU request pending and not yet granted
- mem_req  out  1  SDRAM request, held until mem_ack
- mem_we  out  1  SDRAM write enable
- mem_addr  out  ADDR_W  SDRAM address
- mem_din  out  DATA_W  SDRAM write data
- mem_dout  in  DATA_W  SDRAM read data, valid with mem_ack
- mem_ack  in  1  one-cycle SDRAM completion
- dl_busy  out  1  dl_downloading OR FIFO non-empty OR state == DL
- overflow  out  1  sticky: a downloader write was dropped

Behaviour:
- Reset (async): FIFO empty, state IDLE. All outputs 0: mem_req, mem_we, mem_addr, mem_din, cpu_ack, cpu_dout, overflow. mem_req drops immediately, even mid-transaction; an SDRAM access in flight is abandoned.
- FIFO push: on every clk edge with dl_wr = 1.
  - Full with no pop in the same cycle: entry dropped, overflow set.
  - Full with a pop in the same cycle: push accepted.
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- overflow clears on the rising edge of dl_downloading (edge detected with a registered copy).
- FSM states IDLE, DL, CPU:
  - IDLE, FIFO non-empty: pop head; load mem_addr/mem_din from it; mem_we = 1; mem_req = 1; go to DL.
  - IDLE, FIFO empty and dl_downloading = 0 and cpu_req = 1: latch cpu_addr/cpu_din/cpu_we into mem_*; mem_req = 1; go to CPU.
  - IDLE, otherwise: stay; mem_req = 0.
  - DL: hold mem_* until mem_ack. On mem_ack: mem_req = 0, mem_we = 0, go to IDLE.
  - CPU: hold until mem_ack. On mem_ack: mem_req = 0; cpu_ack = 1 for the next cycle only; cpu_dout <= mem_dout if read, otherwise unchanged; go to IDLE.
- Priority:
  - FIFO always beats CPU.
  - CPU is locked out for the whole of dl_downloading = 1, even when the FIFO is empty.
  - After dl_downloading falls, the CPU is granted only once the FIFO has drained. This covers the downloader's trailing pointer writes.
- Latency:
  - dl_wr sampled at edge N → mem_req high from cycle N+2 if IDLE (N+1 push-visible, pop/issue at edge N+1).
  - Back-to-back accesses have at least one IDLE cycle between mem_ack and the next mem_req.
- cpu_wait = cpu_req AND state != CPU AND NOT cpu_ack (combinational).
- cpu_req is sampled only in IDLE. Once latched, the transaction completes even if cpu_req drops. cpu_req must deassert in the cycle cpu_ack is seen, otherwise a new access is issued.
- mem_ack received in IDLE is ignored.
- dl_wr during an active CPU access is queued, never lost (up to FIFO_DEPTH).

Decomposition:
- Package sdram_arb_pkg: state enum arb_state_t {IDLE, DL, CPU}; localparam functions for the FIFO pointer width.
- Sub-module dl_write_fifo: parameterised synchronous FIFO holding {addr, data}. Ports: push/pop/full/empty/count; asynchronous active-high reset.
- The arbiter FSM lives in the top module.

Test Plan:
- Single write: dl_downloading = 1, dl_wr with addr 0x10000 and data 0xA5; SDRAM model acks after 3 cycles → mem_req rises 2 cycles after the strobe; mem_we = 1, mem_addr = 0x10000, mem_din = 0xA5; mem_req held exactly until the ack.
- Burst within capacity: 4 dl_wr in consecutive cycles, mem_ack latency 5 → all 4 written in order; overflow stays 0.
- Burst over capacity: 6 dl_wr in consecutive cycles, no ack for 10 cycles → overflow = 1; exactly 5 entries written (one in flight, four in FIFO); overflow clears on the next dl_downloading rise.
- CPU lockout: cpu_req read of 0x00123 while dl_downloading = 1 → cpu_wait stays 1. Drop dl_downloading with 2 entries still queued → both entries are written first, then the CPU read; memory returns 0x3C → cpu_ack pulses 1 cycle with cpu_dout = 0x3C.
- CPU in flight: dl_wr arrives during a CPU write → the CPU write completes first; the downloader write issues from IDLE next.
- Reset mid-access: assert reset while mem_req = 1 → mem_req, cpu_ack and overflow drop asynchronously; FIFO empty; no access issues until new stimulus after release.

Source files
------------

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and sizing helpers for the SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DL,
    CPU
  } arb_state_t;

  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return (depth > 1) ? unsigned'($clog2(depth)) : 1;
  endfunction

  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return unsigned'($clog2(depth)) + 1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Downloader, CPU and SDRAM command signals seen by the arbiter.
interface sdram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned DATA_W = 8
);
  logic              dl_downloading;
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_addr;
  logic [DATA_W-1:0] dl_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_ack;
  logic              cpu_wait;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_ack;
  logic              dl_busy;
  logic              overflow;

  // Environment side: downloader, CPU and the SDRAM controller.
  modport master (
    output dl_downloading, dl_wr, dl_addr, dl_data,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output mem_dout, mem_ack,
    input  cpu_dout, cpu_ack, cpu_wait,
    input  mem_req, mem_we, mem_addr, mem_din,
    input  dl_busy, overflow
  );

  // Arbiter side.
  modport slave (
    input  dl_downloading, dl_wr, dl_addr, dl_data,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  mem_dout, mem_ack,
    output cpu_dout, cpu_ack, cpu_wait,
    output mem_req, mem_we, mem_addr, mem_din,
    output dl_busy, overflow
  );
endinterface

// File: rtl/sdram_port_arbiter_fifo.sv
// Small synchronous FIFO absorbing downloader write strobes ({addr, data}).
module dl_write_fifo
  import sdram_arb_pkg::*;
#(
  parameter  int unsigned WIDTH = 33,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = fifo_ptr_w(DEPTH),
  localparam int unsigned CNT_W = fifo_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = store[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates the SDRAM command port between buffered downloader writes and the CPU.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sdram_port_arbiter_if.slave   bus
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = fifo_cnt_w(FIFO_DEPTH);

  arb_state_t        state_q, state_n;
  logic              mem_req_q, mem_req_n;
  logic              mem_we_q, mem_we_n;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
  logic [DATA_W-1:0] mem_din_q, mem_din_n;
  logic              cpu_ack_q, cpu_ack_n;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_n;
  logic              overflow_q, overflow_n;
  logic              dl_prev_q;

  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic               drop;
  logic               dl_rise;

  dl_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.dl_wr),
    .push_data ({bus.dl_addr, bus.dl_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign drop    = bus.dl_wr && fifo_full && !fifo_pop;
  assign dl_rise = bus.dl_downloading && !dl_prev_q;

  always_comb begin
    state_n    = state_q;
    mem_req_n  = mem_req_q;
    mem_we_n   = mem_we_q;
    mem_addr_n = mem_addr_q;
    mem_din_n  = mem_din_q;
    cpu_dout_n = cpu_dout_q;
    cpu_ack_n  = 1'b0;
    fifo_pop   = 1'b0;

    case (state_q)
      IDLE: begin
        mem_req_n = 1'b0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          mem_addr_n = fifo_head[ENTRY_W-1:DATA_W];
          mem_din_n  = fifo_head[DATA_W-1:0];
          mem_we_n   = 1'b1;
          mem_req_n  = 1'b1;
          state_n    = DL;
        end else if (!bus.dl_downloading && bus.cpu_req) begin
          mem_addr_n = bus.cpu_addr;
          mem_din_n  = bus.cpu_din;
          mem_we_n   = bus.cpu_we;
          mem_req_n  = 1'b1;
          state_n    = CPU;
        end
      end
      DL: begin
        if (bus.mem_ack) begin
          mem_req_n = 1'b0;
          mem_we_n  = 1'b0;
          state_n   = IDLE;
        end
      end
      CPU: begin
        if (bus.mem_ack) begin
          mem_req_n = 1'b0;
          cpu_ack_n = 1'b1;
          if (!mem_we_q) cpu_dout_n = bus.mem_dout;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // A drop in the same cycle as a new download start keeps the flag set.
    overflow_n = overflow_q;
    if (drop)         overflow_n = 1'b1;
    else if (dl_rise) overflow_n = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      cpu_ack_q  <= 1'b0;
      cpu_dout_q <= '0;
      overflow_q <= 1'b0;
      dl_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      mem_req_q  <= mem_req_n;
      mem_we_q   <= mem_we_n;
      mem_addr_q <= mem_addr_n;
      mem_din_q  <= mem_din_n;
      cpu_ack_q  <= cpu_ack_n;
      cpu_dout_q <= cpu_dout_n;
      overflow_q <= overflow_n;
      dl_prev_q  <= bus.dl_downloading;
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.cpu_dout = cpu_dout_q;
  assign bus.overflow = overflow_q;
  assign bus.cpu_wait = bus.cpu_req && (state_q != CPU) && !cpu_ack_q;
  assign bus.dl_busy  = bus.dl_downloading || (fifo_count != '0) || (state_q == DL);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with an SDRAM responder and an in-order access scoreboard.
module tb_sdram_port_arbiter;

  localparam int unsigned AW    = 25;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  txn_t          sb[$];
  int unsigned   errors = 0;
  int unsigned   checks = 0;
  int unsigned   lat    = 3;
  int unsigned   issued = 0;
  logic [DW-1:0] rd_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // SDRAM responder: checks each new access against the scoreboard head, acks after lat cycles.
  initial begin : sdram_model
    txn_t        cur;
    txn_t        exp;
    int unsigned cnt;
    bit          active;
    bit          acked;
    active = 0; acked = 0; cnt = 0;
    bus.mem_ack  = 1'b0;
    bus.mem_dout = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (reset) begin
        active = 0;
        acked  = 0;
        continue;
      end
      if (acked) begin
        chk("req_low_after_ack", bus.mem_req, 0);
        acked = 0;
      end else if (active) begin
        chk("req_held", bus.mem_req, 1);
        chk("addr_held", bus.mem_addr, cur.addr);
        chk("we_held", bus.mem_we, cur.we);
        cnt++;
      end else if (bus.mem_req) begin
        cur.we = bus.mem_we; cur.addr = bus.mem_addr; cur.data = bus.mem_din;
        chk("access_expected", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          chk("acc_we", cur.we, exp.we);
          chk("acc_addr", cur.addr, exp.addr);
          chk("acc_din", cur.data, exp.data);
        end
        issued++;
        active = 1;
        cnt    = 1;
      end
      if (active && cnt >= lat) begin
        bus.mem_ack  = 1'b1;
        bus.mem_dout = rd_data;
        active = 0;
        acked  = 1;
      end
    end
  end

  task automatic dl_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_it);
    bus.dl_wr   = 1'b1;
    bus.dl_addr = a;
    bus.dl_data = d;
    if (expect_it) sb.push_back('{1'b1, a, d});
    @(negedge clk);
    bus.dl_wr = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (!(sb.size() == 0 && !bus.mem_req) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk(tag, sb.size(), 0);
  endtask

  task automatic wait_req(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (!bus.mem_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk(tag, bus.mem_req, 1);
  endtask

  task automatic wait_cpu_ack(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (!bus.cpu_ack && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk(tag, bus.cpu_ack, 1);
  endtask

  initial begin : stimulus
    int unsigned base;
    reset = 1'b1;
    bus.dl_downloading = 1'b0;
    bus.dl_wr = 1'b0; bus.dl_addr = '0; bus.dl_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_din", bus.mem_din, 0);
    chk("rst_cpu_ack", bus.cpu_ack, 0);
    chk("rst_cpu_dout", bus.cpu_dout, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_dl_busy", bus.dl_busy, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single write: request appears on the second edge after the strobe.
    lat = 3;
    bus.dl_downloading = 1'b1;
    @(negedge clk);
    dl_write(25'h10000, 8'hA5, 1);
    chk("t1_req_after_push_edge", bus.mem_req, 0);
    @(negedge clk);
    chk("t1_req_after_issue_edge", bus.mem_req, 1);
    chk("t1_we", bus.mem_we, 1);
    chk("t1_addr", bus.mem_addr, 32'h10000);
    chk("t1_din", bus.mem_din, 32'hA5);
    wait_drain("t1_drain_timeout", 30);
    chk("t1_overflow", bus.overflow, 0);

    // Burst within capacity.
    lat  = 5;
    base = issued;
    for (int i = 0; i < 4; i++) dl_write(25'h00400 + 25'(i), 8'h10 + 8'(i), 1);
    wait_drain("t2_drain_timeout", 80);
    chk("t2_count", issued - base, 4);
    chk("t2_overflow", bus.overflow, 0);

    // Burst over capacity: one in flight plus four queued, the sixth dropped.
    lat  = 10;
    base = issued;
    for (int i = 0; i < 6; i++) dl_write(25'h00800 + 25'(i), 8'h20 + 8'(i), i < 5);
    chk("t3_overflow_set", bus.overflow, 1);
    wait_drain("t3_drain_timeout", 120);
    chk("t3_count", issued - base, 5);
    bus.dl_downloading = 1'b0;
    @(negedge clk);
    chk("t3_overflow_sticky", bus.overflow, 1);
    bus.dl_downloading = 1'b1;
    @(negedge clk);
    chk("t3_overflow_cleared", bus.overflow, 0);

    // CPU locked out during download; queued writes drain before the read.
    lat  = 6;
    base = issued;
    rd_data = 8'h3C;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 25'h00123; bus.cpu_din = '0;
    for (int i = 0; i < 3; i++) dl_write(25'h01000 + 25'(i), 8'h40 + 8'(i), 1);
    sb.push_back('{1'b0, 25'h00123, 8'h00});
    chk("t4_wait_locked", bus.cpu_wait, 1);
    @(negedge clk);
    chk("t4_wait_locked2", bus.cpu_wait, 1);
    bus.dl_downloading = 1'b0;
    wait_cpu_ack("t4_ack_timeout", 80);
    chk("t4_cpu_dout", bus.cpu_dout, 32'h3C);
    chk("t4_wait_at_ack", bus.cpu_wait, 0);
    chk("t4_count", issued - base, 4);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("t4_ack_pulse", bus.cpu_ack, 0);
    wait_drain("t4_drain_timeout", 20);

    // Downloader write arriving during a CPU write is queued behind it.
    lat  = 4;
    base = issued;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 25'h00200; bus.cpu_din = 8'h77;
    sb.push_back('{1'b1, 25'h00200, 8'h77});
    wait_req("t5_req_timeout", 10);
    chk("t5_wait_granted", bus.cpu_wait, 0);
    dl_write(25'h00300, 8'h11, 1);
    wait_cpu_ack("t5_ack_timeout", 20);
    bus.cpu_req = 1'b0;
    chk("t5_dout_unchanged", bus.cpu_dout, 32'h3C);
    wait_drain("t5_drain_timeout", 30);
    chk("t5_count", issued - base, 2);

    // Reset in the middle of an access with a full FIFO and overflow set.
    lat = 20;
    bus.dl_downloading = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) dl_write(25'h02000 + 25'(i), 8'h60 + 8'(i), i < 5);
    chk("t6_pre_req", bus.mem_req, 1);
    chk("t6_pre_overflow", bus.overflow, 1);
    bus.dl_downloading = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_mem_req", bus.mem_req, 0);
    chk("t6_rst_overflow", bus.overflow, 0);
    chk("t6_rst_cpu_ack", bus.cpu_ack, 0);
    chk("t6_rst_mem_we", bus.mem_we, 0);
    chk("t6_rst_dl_busy", bus.dl_busy, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    base  = issued;
    repeat (5) @(negedge clk);
    chk("t6_quiet_req", bus.mem_req, 0);
    chk("t6_quiet_count", issued - base, 0);
    lat = 2;
    dl_write(25'h00055, 8'h5A, 1);
    wait_drain("t6_drain_timeout", 20);
    chk("t6_new_count", issued - base, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
